riscv_str_decode: RTL and testbench

Multi-cycle string decode unit in the RI5CY EX stage, the inverse counterpart of the string leet/upper encode unit. It converts a packed 4-byte ASCII word back to plain text. It processes one byte per cycle under a small FSM and uses the same enable/ready/ex_ready handshake as the other multi-cycle EX units. Its result is muxed into the EX result path by the core.

---
 rtl/riscv_str_decode.sv | 129 ++++++++++++
 tb/tb_riscv_str_decode.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/riscv_str_decode.sv
// riscv_str_decode: multi-cycle string decode unit for the RI5CY EX stage.
// Inverse of the leet/upper encode unit: turns a packed 4-byte ASCII word
// back into plain text, one byte per cycle, behind the EX-stage
// enable/ready/ex_ready handshake.
// Optional feature: define STR_DEC_ROT13_EN to build the ROT13 transform;
// without it STR_OP_ROT13 is answered like any unsupported operator.
module riscv_str_decode #(
  parameter int STR_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i,
  output logic [31:0]             result_o,
  output logic                    ready_o,
  input  logic                    ex_ready_i
);

  // Operator codes shared with riscv_defines.
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER  = STR_OP_WIDTH'(2);
`ifdef STR_DEC_ROT13_EN
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13  = STR_OP_WIDTH'(3);
`endif
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UNLEET = STR_OP_WIDTH'(4);

  localparam logic [31:0] BAD_OP_RESULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [STR_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             word_q, word_d;
  logic [1:0]              idx_q, idx_d;

  logic                    w_supported;
  logic [4:0]              w_bit_pos;
  logic [7:0]              w_byte_in;
  logic [7:0]              w_byte_out;

  // Per-byte decode; bytes outside each operator's range pass through.
  function automatic logic [7:0] decode_byte(input logic [STR_OP_WIDTH-1:0] op,
                                             input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (op == STR_OP_UNLEET) begin
      case (b)
        8'h33:   r = 8'h65;
        8'h35:   r = 8'h73;
        8'h31:   r = 8'h6C;
        default: r = b;
      endcase
    end else if (op == STR_OP_LOWER) begin
      if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
`ifdef STR_DEC_ROT13_EN
    end else if (op == STR_OP_ROT13) begin
      // Ranges keep the result inside the same letter case, so 8-bit math never wraps.
      if ((b >= 8'h41 && b <= 8'h4D) || (b >= 8'h61 && b <= 8'h6D))
        r = b + 8'd13;
      else if ((b >= 8'h4E && b <= 8'h5A) || (b >= 8'h6E && b <= 8'h7A))
        r = b - 8'd13;
`endif
    end
    return r;
  endfunction

  // Operator support check and current-byte decode.
  always_comb begin
    w_supported = (operator_i == STR_OP_UNLEET) || (operator_i == STR_OP_LOWER);
`ifdef STR_DEC_ROT13_EN
    if (operator_i == STR_OP_ROT13) w_supported = 1'b1;
`endif
    w_bit_pos  = {idx_q, 3'b000};
    w_byte_in  = word_q[w_bit_pos +: 8];
    w_byte_out = decode_byte(op_q, w_byte_in);
  end

  // Next-state and handshake outputs; idle default is ready with a zero result.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    idx_d    = idx_q;
    ready_o  = 1'b1;
    result_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          if (w_supported) begin
            word_d  = operand_i;
            op_d    = operator_i;
            idx_d   = 2'd0;
            state_d = BUSY;
            ready_o = 1'b0;
          end else begin
            result_o = BAD_OP_RESULT;
          end
        end
      end
      BUSY: begin
        ready_o = 1'b0;
        word_d[w_bit_pos +: 8] = w_byte_out;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        result_o = word_q;
        if (ex_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation and clears the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      word_q  <= 32'h0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_riscv_str_decode.sv
// Testbench for riscv_str_decode: scoreboard queue of expected results,
// filled when a request is driven and drained when the unit answers.
module tb_riscv_str_decode;

  localparam logic [2:0] OP_UPPER  = 3'd0;
  localparam logic [2:0] OP_LOWER  = 3'd2;
  localparam logic [2:0] OP_ROT13  = 3'd3;
  localparam logic [2:0] OP_UNLEET = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [2:0]  operator_i;
  logic [31:0] operand_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        ex_ready_i;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  riscv_str_decode #(.STR_OP_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable_i),
    .operator_i(operator_i),
    .operand_i (operand_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .ex_ready_i(ex_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Supported request: accept, 4 busy cycles, DONE (optionally stalled), back to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] opnd,
                        input logic [31:0] exp, input int stall);
    logic [31:0] e;
    int busy;
    enable_i   = 1'b1;
    operator_i = op;
    operand_i  = opnd;
    ex_ready_i = (stall == 0);
    exp_q.push_back(exp);
    #1;
    check({tag, "_acc_rdy"}, 32'(ready_o), 32'd0);
    @(negedge clk);
    // Junk on the request inputs while busy must be ignored.
    operator_i = OP_UPPER;
    operand_i  = 32'hFFFF_FFFF;
    busy = 0;
    while (!ready_o && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(busy), 32'd4);
    enable_i = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_result"}, result_o, e);
      check({tag, "_done_rdy"}, 32'(ready_o), 32'd1);
      if (i == stall) ex_ready_i = 1'b1;
    end
    @(negedge clk);
    check({tag, "_idle_result"}, result_o, 32'h0);
    check({tag, "_idle_rdy"}, 32'(ready_o), 32'd1);
  endtask

  // Unsupported request: same-cycle DEADBEEF, no transition to busy.
  task automatic run_bad(input string tag, input logic [2:0] op, input logic [31:0] opnd);
    logic [31:0] e;
    enable_i   = 1'b1;
    operator_i = op;
    operand_i  = opnd;
    ex_ready_i = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    e = exp_q.pop_front();
    check({tag, "_result"}, result_o, e);
    check({tag, "_rdy"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    enable_i = 1'b0;
    #1;
    check({tag, "_after_rdy"}, 32'(ready_o), 32'd1);
    check({tag, "_after_result"}, result_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    enable_i   = 1'b0;
    operator_i = OP_UPPER;
    operand_i  = 32'h0;
    ex_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(ready_o), 32'd1);
    check("rst_result", result_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(ready_o), 32'd1);
    check("post_rst_result", result_o, 32'h0);

    run_op("unleet", OP_UNLEET, 32'h3135_3333, 32'h6C73_6565, 0);
    run_op("unleet_mix", OP_UNLEET, 32'h3234_3531, 32'h3234_736C, 0);
    run_op("lower_stall", OP_LOWER, 32'h5A41_6162, 32'h7A61_6162, 10);
    run_op("lower_edge", OP_LOWER, 32'h5B40_5A41, 32'h5B40_7A61, 0);
`ifdef STR_DEC_ROT13_EN
    run_op("rot13", OP_ROT13, 32'h6D6E_4D4E, 32'h7A61_5A41, 0);
`else
    run_bad("rot13_off", OP_ROT13, 32'h6D6E_4D4E);
`endif
    run_bad("upper", OP_UPPER, 32'h6162_6364);

    // Reset asserted two cycles into an UNLEET request.
    @(negedge clk);
    enable_i   = 1'b1;
    operator_i = OP_UNLEET;
    operand_i  = 32'h3135_3333;
    ex_ready_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(ready_o), 32'd1);
    check("midrst_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_rdy", 32'(ready_o), 32'd1);
    check("midrst_idle_result", result_o, 32'h0);
    run_op("after_rst", OP_UNLEET, 32'h0000_0033, 32'h0000_0065, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
